// File: rtl/puf_eval_sequencer_if.sv
// PUF array and key handshake bundle for puf_eval_sequencer.
// With PUF_STABILITY_EN defined the bundle also carries unstable_mask.
interface puf_eval_sequencer_if #(
  parameter int unsigned NUM_CHAL = 4
);
  logic                  start;
  logic                  busy;
  logic [0:7]            puf_challenge;
  logic                  puf_en;
  logic                  puf_clr;
  logic [0:7]            puf_response;
  logic                  key_valid;
  logic                  key_ack;
  logic [8*NUM_CHAL-1:0] key;
`ifdef PUF_STABILITY_EN
  logic [8*NUM_CHAL-1:0] unstable_mask;
`endif

  modport master (
    input  start, puf_response, key_ack,
    output busy, puf_challenge, puf_en, puf_clr, key_valid, key
`ifdef PUF_STABILITY_EN
    , output unstable_mask
`endif
  );

  modport slave (
    output start, puf_response, key_ack,
    input  busy, puf_challenge, puf_en, puf_clr, key_valid, key
`ifdef PUF_STABILITY_EN
    , input unstable_mask
`endif
  );
endinterface

// File: rtl/puf_eval_sequencer.sv
// Ring-oscillator PUF sequencer: LFSR challenges, NUM_VOTES majority votes per bit, packed key handshake.
// Optional macro PUF_STABILITY_EN adds unstable_mask (bits whose votes were not unanimous).
module puf_eval_sequencer #(
  parameter int unsigned EVAL_CYCLES = 64,
  parameter int unsigned NUM_VOTES   = 5,
  parameter int unsigned NUM_CHAL    = 4,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input logic                  clk,
  input logic                  reset,
  puf_eval_sequencer_if.master bus
);
  localparam int unsigned   CW       = $clog2(NUM_VOTES + 1);
  localparam int unsigned   XW       = $clog2(NUM_CHAL + 1);
  localparam int unsigned   RW       = $clog2(EVAL_CYCLES + 2);
  localparam logic [CW-1:0] VOTES_L  = CW'(NUM_VOTES);
  localparam logic [CW-1:0] HALF_L   = CW'(NUM_VOTES / 2);
  localparam logic [XW-1:0] CHAL_L   = XW'(NUM_CHAL);
  localparam logic [RW-1:0] RUN_LAST = RW'(EVAL_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, SETTLE, SAMPLE, NEXT, DONE} state_t;

  state_t        state;
  logic [7:0]    lfsr;
  logic [CW-1:0] cnt [8];
  logic [CW-1:0] vote_idx;
  logic [XW-1:0] chal_idx;
  logic [RW-1:0] tmr;
  logic [7:0]    voted;
  logic          fb;
`ifdef PUF_STABILITY_EN
  logic [7:0]    unstable;
`endif

  assign bus.puf_challenge = lfsr;
  assign fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

  // response[b] lands on key bit 8i+7-b
  always_comb begin
    voted = '0;
    for (int unsigned b = 0; b < 8; b++) begin
      voted[3'(7 - b)] = cnt[b] > HALF_L;
    end
  end

`ifdef PUF_STABILITY_EN
  always_comb begin
    unstable = '0;
    for (int unsigned b = 0; b < 8; b++) begin
      unstable[3'(7 - b)] = (cnt[b] != '0) && (cnt[b] != VOTES_L);
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      lfsr          <= LFSR_SEED;
      for (int unsigned b = 0; b < 8; b++) cnt[b] <= '0;
      vote_idx      <= '0;
      chal_idx      <= '0;
      tmr           <= '0;
      bus.puf_en    <= 1'b0;
      bus.puf_clr   <= 1'b0;
      bus.busy      <= 1'b0;
      bus.key_valid <= 1'b0;
      bus.key       <= '0;
`ifdef PUF_STABILITY_EN
      bus.unstable_mask <= '0;
`endif
    end else begin
      bus.puf_clr <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            lfsr        <= LFSR_SEED;
            for (int unsigned b = 0; b < 8; b++) cnt[b] <= '0;
            vote_idx    <= '0;
            chal_idx    <= '0;
            bus.key     <= '0;
`ifdef PUF_STABILITY_EN
            bus.unstable_mask <= '0;
`endif
            bus.busy    <= 1'b1;
            bus.puf_clr <= 1'b1;
            state       <= CLEAR;
          end
        end
        CLEAR: begin
          bus.puf_en <= 1'b1;
          tmr        <= '0;
          state      <= RUN;
        end
        RUN: begin
          if (tmr == RUN_LAST) begin
            bus.puf_en <= 1'b0;
            tmr        <= '0;
            state      <= SETTLE;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        SETTLE: begin
          if (tmr == RW'(1)) begin
            tmr   <= '0;
            state <= SAMPLE;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        SAMPLE: begin
          for (int unsigned b = 0; b < 8; b++) begin
            cnt[b] <= cnt[b] + CW'(bus.puf_response[3'(b)]);
          end
          vote_idx <= vote_idx + 1'b1;
          if (vote_idx + 1'b1 == VOTES_L) begin
            state <= NEXT;
          end else begin
            bus.puf_clr <= 1'b1;
            state       <= CLEAR;
          end
        end
        NEXT: begin
          bus.key[{chal_idx, 3'b000} +: 8] <= voted;
`ifdef PUF_STABILITY_EN
          bus.unstable_mask[{chal_idx, 3'b000} +: 8] <= unstable;
`endif
          for (int unsigned b = 0; b < 8; b++) cnt[b] <= '0;
          vote_idx <= '0;
          lfsr     <= {lfsr[6:0], fb};
          chal_idx <= chal_idx + 1'b1;
          if (chal_idx + 1'b1 == CHAL_L) begin
            bus.busy <= 1'b0;
            state    <= DONE;
          end else begin
            bus.puf_clr <= 1'b1;
            state       <= CLEAR;
          end
        end
        DONE: begin
          // key_valid rises on the cycle after entry; ack is only honoured once it is up
          if (!bus.key_valid) begin
            bus.key_valid <= 1'b1;
          end else if (bus.key_ack) begin
            bus.key_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_puf_eval_sequencer.sv
// Scoreboard bench for puf_eval_sequencer at EVAL_CYCLES=8, NUM_VOTES=3, NUM_CHAL=2.
// Define PUF_STABILITY_EN to also check unstable_mask.
module tb_puf_eval_sequencer;
  localparam int unsigned EC  = 8;
  localparam int unsigned NV  = 3;
  localparam int unsigned NC  = 2;
  localparam int unsigned LAT = NC * (NV * (EC + 4) + 1) + 1;  // 75

  typedef struct {
    logic [15:0] key;
    logic [15:0] mask;
    int unsigned t0;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  int unsigned cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  exp_t        sb[$];
  logic [7:0]  resp_q[$];
  logic [7:0]  chal_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  puf_eval_sequencer_if #(.NUM_CHAL(NC)) bus ();

  puf_eval_sequencer #(
    .EVAL_CYCLES(EC),
    .NUM_VOTES(NV),
    .NUM_CHAL(NC),
    .LFSR_SEED(8'hA5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // PUF model and evaluation timing monitor
  logic        prev_en, prev_clr, chal_moved;
  int unsigned en_len;
  logic [7:0]  en_chal;
  always @(negedge clk) begin
    if (!reset) begin
      prev_en          = 1'b0;
      prev_clr         = 1'b0;
      chal_moved       = 1'b0;
      en_len           = 0;
      bus.puf_response = 8'h00;
    end else begin
      if (bus.puf_clr) begin
        chk("clr_en_excl", 32'(bus.puf_en), 32'd0);
        if (chal_q.size() == 0) chk("chal_unexpected", chal_q.size(), 32'd1);
        else chk("challenge", 32'(bus.puf_challenge), 32'(chal_q.pop_front()));
        bus.puf_response = (resp_q.size() != 0) ? resp_q.pop_front() : 8'h00;
      end
      if (bus.puf_en && !prev_en) begin
        chk("clr_before_en", 32'(prev_clr), 32'd1);
        en_len     = 0;
        en_chal    = bus.puf_challenge;
        chal_moved = 1'b0;
      end
      if (bus.puf_en) begin
        en_len++;
        if (bus.puf_challenge !== en_chal) chal_moved = 1'b1;
      end
      if (!bus.puf_en && prev_en) begin
        chk("en_len", en_len, EC);
        chk("chal_stable", 32'(chal_moved), 32'd0);
      end
      prev_en  = bus.puf_en;
      prev_clr = bus.puf_clr;
    end
  end

  // key scoreboard monitor
  logic kv_prev;
  exp_t mon_e;
  always @(negedge clk) begin
    if (!reset) begin
      kv_prev = 1'b0;
    end else begin
      if (bus.key_valid && !kv_prev) begin
        if (sb.size() == 0) begin
          chk("key_unexpected", sb.size(), 32'd1);
        end else begin
          mon_e = sb.pop_front();
          chk("key", 32'(bus.key), 32'(mon_e.key));
          chk("latency", cyc - mon_e.t0, LAT);
`ifdef PUF_STABILITY_EN
          chk("unstable_mask", 32'(bus.unstable_mask), 32'(mon_e.mask));
`endif
        end
      end
      kv_prev = bus.key_valid;
    end
  end

  // r holds six responses, first evaluation in the top byte
  task automatic start_run(input logic [47:0] r, input logic [15:0] k, input logic [15:0] m);
    exp_t e;
    for (int i = 0; i < 6; i++) resp_q.push_back(r[8*(5-i) +: 8]);
    for (int i = 0; i < 6; i++) chal_q.push_back((i < 3) ? 8'hA5 : 8'h4A);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    e.key  = k;
    e.mask = m;
    e.t0   = cyc;
    sb.push_back(e);
  endtask

  task automatic wait_key();
    int unsigned n = 0;
    while (!bus.key_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("key_valid_timeout", 32'(bus.key_valid), 32'd1);
  endtask

  task automatic ack(input logic [15:0] k);
    @(negedge clk);
    bus.key_ack = 1'b1;
    @(negedge clk);
    bus.key_ack = 1'b0;
    chk("ack_kv_low", 32'(bus.key_valid), 32'd0);
    chk("ack_key_kept", 32'(bus.key), 32'(k));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b0;
    bus.start   = 1'b0;
    bus.key_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_puf_en", 32'(bus.puf_en), 32'd0);
    chk("rst_puf_clr", 32'(bus.puf_clr), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_key_valid", 32'(bus.key_valid), 32'd0);
    chk("rst_key", 32'(bus.key), 32'd0);
    chk("rst_challenge", 32'(bus.puf_challenge), 32'h0000_00A5);
`ifdef PUF_STABILITY_EN
    chk("rst_mask", 32'(bus.unstable_mask), 32'd0);
`endif
    reset = 1'b1;

    // constant response
    start_run(48'h3C3C3C3C3C3C, 16'h3C3C, 16'h0000);
    wait_key();

    // DONE hold with an ignored start
    for (int i = 0; i < 10; i++) begin
      bus.start = (i == 4);
      @(negedge clk);
      chk("done_valid", 32'(bus.key_valid), 32'd1);
      chk("done_key", 32'(bus.key), 32'h0000_3C3C);
      chk("done_busy", 32'(bus.busy), 32'd0);
    end
    bus.start = 1'b0;

    // ack and start together: ack wins
    bus.key_ack = 1'b1;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.key_ack = 1'b0;
    bus.start   = 1'b0;
    chk("ackstart_kv", 32'(bus.key_valid), 32'd0);
    chk("ackstart_busy", 32'(bus.busy), 32'd0);
    chk("ackstart_clr", 32'(bus.puf_clr), 32'd0);
    @(negedge clk);
    chk("idle_key_kept", 32'(bus.key), 32'h0000_3C3C);
    chk("idle_busy", 32'(bus.busy), 32'd0);

    // majority vote: FF,0F,F0 -> FF ; 00,00,FF -> 00
    start_run(48'hFF0FF00000FF, 16'h00FF, 16'hFFFF);
    chk("start_key_clr", 32'(bus.key), 32'd0);
    chk("start_challenge", 32'(bus.puf_challenge), 32'h0000_00A5);
    chk("start_busy", 32'(bus.busy), 32'd1);
    repeat (20) @(negedge clk);
    bus.key_ack = 1'b1;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.key_ack = 1'b0;
    bus.start   = 1'b0;
    chk("busy_ignores", 32'(bus.busy), 32'd1);
    wait_key();
    ack(16'h00FF);

    // unanimous votes: AA x3 -> AA, 55 x3 -> 55
    start_run(48'hAAAAAA555555, 16'h55AA, 16'h0000);
    wait_key();
    ack(16'h55AA);

    // reset during RUN
    resp_q.push_back(8'h11);
    chal_q.push_back(8'hA5);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 10 && !bus.puf_en; i++) @(negedge clk);
    chk("abort_in_run", 32'(bus.puf_en), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("abort_en_drop", 32'(bus.puf_en), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_challenge", 32'(bus.puf_challenge), 32'h0000_00A5);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("abort_no_key", 32'(bus.key_valid), 32'd0);
    end

    chk("sb_drained", sb.size(), 32'd0);
    chk("resp_drained", resp_q.size(), 32'd0);
    chk("chal_drained", chal_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/puf_eval_sequencer.md
Name: puf_eval_sequencer

Overview:
- Drives the 8-bit ring-oscillator PUF array and consumes its 8-bit response.
- Generates challenges from an LFSR and runs NUM_VOTES timed evaluations per challenge.
- Majority-votes each response bit and packs NUM_CHAL voted bytes into a key.
- Hands the key downstream with a valid/ack handshake.

Parameters:
- EVAL_CYCLES, 64: cycles puf_en is held high per evaluation (>=1).
- NUM_VOTES, 5: evaluations per challenge; odd, 1..15.
- NUM_CHAL, 4: challenges per key, 1..16.
- LFSR_SEED, 8'hA5: first challenge after start; nonzero.

Ports:
- clk, in, 1: system clock, rising edge.
- reset, in, 1: asynchronous, active-low; 0 resets everything.
- start, in, 1: request a key; sampled only in IDLE.
- puf_challenge, out, [0:7]: challenge to the PUF array.
- puf_en, out, 1: PUF oscillator enable.
- puf_clr, out, 1: one-cycle active-high clear to the PUF counters.
- puf_response, in, [0:7]: PUF response; sampled only in SAMPLE.
- busy, out, 1: high in every state except IDLE and DONE.
- key_valid, out, 1: key is stable and available.
- key_ack, in, 1: consumer accepts the key.
- key, out, 8*NUM_CHAL: packed voted key.

Behaviour:
- Reset (reset=0, async): state=IDLE; lfsr=LFSR_SEED; all vote counters, challenge index and vote index = 0; puf_en=0, puf_clr=0, busy=0, key_valid=0, key=0; puf_challenge=LFSR_SEED. Reset mid-run aborts immediately and emits no partial key.
- LFSR: internal lfsr[7:0]; puf_challenge[0] = lfsr[7] … puf_challenge[7] = lfsr[0].
  - Feedback fb = lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]; next = {lfsr[6:0], fb}.
  - Advances only in NEXT; lfsr is reloaded to LFSR_SEED on an accepted start.
  - Sequence from A5: 4A, 95, …
- FSM:
  - IDLE: start=1 → CLEAR. Load seed; clear key, counters and indices.
  - CLEAR: 1 cycle, puf_clr=1 → RUN.
  - RUN: puf_en=1 for exactly EVAL_CYCLES cycles → SETTLE.
  - SETTLE: 2 cycles, puf_en=0 → SAMPLE.
  - SAMPLE: 1 cycle. Each vote counter cnt[b] += puf_response[b]; vote index++.
    - If votes < NUM_VOTES → CLEAR.
    - Else → NEXT.
  - NEXT: 1 cycle. bit b = (cnt[b] > NUM_VOTES/2).
    - Store the voted byte into key slot i = challenge index, with response[0] → key[8i+7] and response[7] → key[8i].
    - Clear counters and vote index; advance LFSR; challenge index++.
    - If index == NUM_CHAL → DONE, else → CLEAR.
  - DONE: key_valid=1, busy=0. key_ack=1 → IDLE with key_valid=0 next cycle; key holds until the next accepted start.
- Counter width: $clog2(NUM_VOTES+1) bits; cannot overflow.
- puf_challenge is stable from CLEAR through SAMPLE of every evaluation.
- Latency from the start-accepting edge to key_valid rising: NUM_CHAL*(NUM_VOTES*(EVAL_CYCLES+4)+1)+1 cycles. Defaults: 1365.
- Boundaries:
  - start while busy or in DONE: ignored.
  - key_ack outside DONE: ignored.
  - start and key_ack together in DONE: ack honoured, start ignored.
  - NUM_VOTES=1: raw single-shot key.
  - puf_clr and puf_en are never high together.

Optional Feature:
- Macro PUF_STABILITY_EN.
- Defined: adds output unstable_mask, width 8*NUM_CHAL, same packing as key.
  - A bit is set when its votes were not unanimous (0 < cnt < NUM_VOTES).
  - Written in NEXT, cleared on start and on reset, valid with key_valid.
- Undefined: the port and its logic are absent; key behaviour is identical.

Test Plan:
- Reset values: hold reset=0, toggle clk → all outputs 0, puf_challenge=8'hA5; assert reset=0 during RUN → puf_en drops the same cycle and key_valid stays 0.
- Challenge sequence: EVAL_CYCLES=8, NUM_VOTES=3, NUM_CHAL=2, response tied 8'h3C, start pulse → challenges A5 then 4A; key_valid after exactly 2*(3*12+1)+1 = 75 cycles; key=16'h3C3C.
- Majority vote: NUM_VOTES=3, responses per evaluation FF, 0F, F0 → voted byte FF; responses 00, 00, FF → 00.
- Timing/exclusivity: EVAL_CYCLES=8 → each puf_en pulse is exactly 8 cycles, preceded by a 1-cycle puf_clr, never overlapping; puf_challenge is constant per evaluation.
- Handshake: in DONE hold key_ack=0 for 10 cycles → key_valid stays 1 and key stable; a start there is ignored; key_ack=1 → IDLE next cycle, key retained; new start → key cleared, lfsr=A5.
- PUF_STABILITY_EN: responses FF, 0F, F0 → key byte FF, mask byte FF; responses AA×3 → mask byte 00.
